// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the canonical NOP and the
// instruction-fetch state encodings.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    OUT   = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch: one ROM read in flight at a time, a one-entry
// output register towards decode, and branch/jump redirects from execute.
module instr_fetch #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misaligned
);
  import cpu_pkg::*;

  localparam logic [XLEN-1:0] NOP_W   = XLEN'(NOP_INSTR);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Handshakes: ROM side holds mem_req/mem_addr until the single mem_ready
  // pulse; decode side holds if_valid/if_instr/if_pc until id_ready is seen
  // high while if_valid is high. A redirect overrides both in any cycle.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            misaligned_q, misaligned_d;
  // A ROM response is still owed for a request abandoned on the way into HALT.
  logic            owe_q, owe_d;
  logic            req_c;
  logic            redirect_bad;
  logic            awaiting_resp;

  assign redirect_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign awaiting_resp = !mem_ready &&
                         ((state_q == WAIT) || (state_q == DRAIN) ||
                          ((state_q == HALT) && owe_q));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    misaligned_d = misaligned_q;
    owe_d        = owe_q;
    req_c        = 1'b0;

    if (owe_q && mem_ready) begin
      owe_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        // A same-cycle redirect withholds the request so nothing stale is in flight.
        req_c   = !redirect_valid;
        state_d = WAIT;
      end
      WAIT: begin
        req_c = 1'b1;
        if (mem_ready) begin
          if_instr_d = mem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if (redirect_bad) begin
        state_d      = HALT;
        misaligned_d = 1'b1;
        owe_d        = awaiting_resp;
      end else begin
        misaligned_d = 1'b0;
        owe_d        = 1'b0;
        state_d      = awaiting_resp ? DRAIN : FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_W;
      if_pc_q      <= RESET_PC;
      misaligned_q <= 1'b0;
      owe_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      misaligned_q <= misaligned_d;
      owe_q        <= owe_d;
    end
  end

  assign mem_req          = req_c && reset_n;
  assign mem_addr         = pc_q;
  assign if_valid         = if_valid_q;
  assign if_instr         = if_instr_q;
  assign if_pc            = if_pc_q;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized redirects,
// stalls and ROM latencies checked against a program-order stream model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .id_ready         (id_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // ROM: latches a request, answers once after rom_lat cycles even if abandoned.
  int          rom_lat = 1;
  logic        rom_pend = 1'b0;
  logic [31:0] rom_paddr = '0;
  int          rom_cnt = 0;

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (rom_pend) begin
      if (rom_cnt <= 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= rom_word(rom_paddr);
        rom_pend  <= 1'b0;
      end else begin
        rom_cnt <= rom_cnt - 1;
      end
    end else if (mem_req && !mem_ready) begin
      if (rom_lat <= 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= rom_word(mem_addr);
      end else begin
        rom_pend  <= 1'b1;
        rom_paddr <= mem_addr;
        rom_cnt   <= rom_lat - 1;
      end
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] a;
  logic [31:0] exp_pc;
  logic        exp_mis;
  logic        prev_valid, prev_ready, prev_redirect;
  logic [31:0] prev_pc, prev_instr;
  int          n_hand;

  initial begin
    reset_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    cyc();
    chk1("rst_mem_req", mem_req, 1'b0);
    cyc();
    chk1 ("rst_if_valid", if_valid, 1'b0);
    chk32("rst_if_instr", if_instr, NOP);
    chk32("rst_if_pc", if_pc, RESET_PC);
    chk1 ("rst_misaligned", fetch_misaligned, 1'b0);
    chk1 ("rst_mem_req2", mem_req, 1'b0);

    // Back-to-back fetches, 1-cycle ROM, decode always ready; third one stalls.
    exp_q = {32'h0, 32'h4, 32'h8};
    @(negedge clk); reset_n = 1'b1; id_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      a = exp_q.pop_front();
      chk1 ("seq_fetch_req", mem_req, 1'b1);
      chk32("seq_fetch_addr", mem_addr, a);
      chk1 ("seq_fetch_valid", if_valid, 1'b0);
      cyc();
      chk1 ("seq_wait_req", mem_req, 1'b1);
      chk32("seq_wait_addr", mem_addr, a);
      @(negedge clk); if (i == 2) id_ready = 1'b0; #1;
      chk1 ("seq_out_valid", if_valid, 1'b1);
      chk32("seq_out_pc", if_pc, a);
      chk32("seq_out_instr", if_instr, rom_word(a));
      chk1 ("seq_out_req", mem_req, 1'b0);
      if (i < 2) cyc();
    end

    repeat (5) begin
      cyc();
      chk1 ("stall_valid", if_valid, 1'b1);
      chk32("stall_pc", if_pc, 32'h8);
      chk32("stall_instr", if_instr, rom_word(32'h8));
      chk1 ("stall_req", mem_req, 1'b0);
    end

    // Loop-back branch arriving together with id_ready.
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0; id_ready = 1'b1; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk1 ("loop_valid", if_valid, 1'b0);
    chk1 ("loop_req", mem_req, 1'b1);
    chk32("loop_addr", mem_addr, 32'h0);
    cyc();
    @(negedge clk); rom_lat = 3; #1;
    chk32("loop_out_pc", if_pc, 32'h0);
    chk32("loop_out_instr", if_instr, rom_word(32'h0));

    // Redirect during a slow ROM read: stale word must be drained and dropped.
    cyc();
    chk32("drain_fetch_addr", mem_addr, 32'h4);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk1("drain_wait_req", mem_req, 1'b1);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk1("drain_req_a", mem_req, 1'b0);
    chk1("drain_valid_a", if_valid, 1'b0);
    @(negedge clk); rom_lat = 1; #1;
    chk1("drain_req_b", mem_req, 1'b0);
    chk1("drain_valid_b", if_valid, 1'b0);
    cyc();
    chk1 ("drain_refetch_req", mem_req, 1'b1);
    chk32("drain_refetch_addr", mem_addr, 32'h40);
    cyc();
    chk1("drain_wait_valid", if_valid, 1'b0);
    cyc();
    chk1 ("drain_out_valid", if_valid, 1'b1);
    chk32("drain_out_pc", if_pc, 32'h40);
    chk32("drain_out_instr", if_instr, rom_word(32'h40));

    // Misaligned target halts fetch until an aligned redirect.
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
    chk1("mis_fetch_req", mem_req, 1'b0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk1("mis_flag", fetch_misaligned, 1'b1);
    chk1("mis_valid", if_valid, 1'b0);
    repeat (2) begin
      cyc();
      chk1("mis_halt_req", mem_req, 1'b0);
      chk1("mis_halt_flag", fetch_misaligned, 1'b1);
    end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h44; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk1 ("mis_clear_flag", fetch_misaligned, 1'b0);
    chk1 ("mis_clear_req", mem_req, 1'b1);
    chk32("mis_clear_addr", mem_addr, 32'h44);
    cyc();
    @(negedge clk); rom_lat = 3; #1;
    chk32("mis_out_pc", if_pc, 32'h44);
    chk32("mis_out_instr", if_instr, rom_word(32'h44));

    // Reset while waiting on the ROM; its late answer must be ignored.
    cyc();
    chk32("rstw_fetch_addr", mem_addr, 32'h48);
    cyc();
    @(negedge clk); reset_n = 1'b0; #1;
    chk1("rstw_req_a", mem_req, 1'b0);
    @(negedge clk); rom_lat = 1; #1;
    chk1("rstw_req_b", mem_req, 1'b0);
    chk1("rstw_valid_b", if_valid, 1'b0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk1 ("rstw_req_c", mem_req, 1'b1);
    chk32("rstw_addr_c", mem_addr, RESET_PC);
    chk1 ("rstw_valid_c", if_valid, 1'b0);
    cyc();
    chk1("rstw_valid_d", if_valid, 1'b0);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk1 ("rstw_out_valid", if_valid, 1'b1);
    chk32("rstw_out_pc", if_pc, RESET_PC);
    chk32("rstw_out_instr", if_instr, rom_word(RESET_PC));

    // pc wrap at the top of the address space.
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk32("wrap_fetch_addr", mem_addr, 32'hFFFF_FFFC);
    cyc();
    cyc();
    chk32("wrap_out_pc", if_pc, 32'hFFFF_FFFC);
    chk32("wrap_out_instr", if_instr, rom_word(32'hFFFF_FFFC));
    cyc();
    chk1 ("wrap_next_req", mem_req, 1'b1);
    chk32("wrap_next_addr", mem_addr, 32'h0);

    @(negedge clk); reset_n = 1'b0; #1;
    cyc();

    // Random phase: every instruction decode accepts must follow program order.
    exp_pc = RESET_PC; exp_mis = 1'b0; n_hand = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_redirect = 1'b0;
    prev_pc = '0; prev_instr = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0) reset_n = 1'b1;
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 5) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      rom_lat        = $urandom_range(1, 4);
      #1;
      if (prev_redirect) begin
        chk1("rnd_valid_after_redirect", if_valid, 1'b0);
      end else if (prev_valid && !prev_ready) begin
        chk1 ("rnd_stall_valid", if_valid, 1'b1);
        chk32("rnd_stall_pc", if_pc, prev_pc);
        chk32("rnd_stall_instr", if_instr, prev_instr);
      end
      chk1("rnd_misaligned", fetch_misaligned, exp_mis);
      if (exp_mis) chk1("rnd_halt_req", mem_req, 1'b0);
      if (rom_pend && mem_req) chk32("rnd_held_addr", mem_addr, rom_paddr);
      if (if_valid && id_ready && !redirect_valid) begin
        chk32("rnd_pc", if_pc, exp_pc);
        chk32("rnd_instr", if_instr, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_hand++;
      end
      if (redirect_valid) begin
        if (redirect_pc[1:0] == 2'b00) begin
          exp_pc  = redirect_pc;
          exp_mis = 1'b0;
        end else begin
          exp_mis = 1'b1;
        end
      end
      prev_valid    = if_valid;
      prev_ready    = id_ready;
      prev_redirect = redirect_valid;
      prev_pc       = if_pc;
      prev_instr    = if_instr;
    end
    chk1("rnd_progress", (n_hand > 100), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
